// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg: shared FSM state encoding and strobe-width helper for the burst memory.
package mem_burst_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    function automatic int strb_width(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/mem_burst_array.sv
// mem_burst_array: single-port RAM with byte strobes and a 1-cycle registered read.
module mem_burst_array
    import mem_burst_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_LINES = 10,
    parameter int STRB_W     = strb_width(WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_LINES-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [STRB_W-1:0]     strb_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic             in_range;

    // Out-of-range accesses drop writes and read back zero.
    assign in_range = {1'b0, addr_i} < (ADDR_LINES+1)'(DEPTH);
    assign rdata_o  = rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i && in_range)
            for (int b = 0; b < STRB_W; b++)
                if (strb_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        if (re_i) rdata_q <= in_range ? mem[addr_i] : '0;
    end

endmodule

// File: rtl/mem_burst_bd.sv
// mem_burst_bd: burst front door plus priority backdoor port sharing one RAM port.
module mem_burst_bd
    import mem_burst_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_LINES = 10,
    parameter int BLEN_W     = 4,
    parameter int STRB_W     = strb_width(WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  wr_rd_i,
    input  logic [ADDR_LINES-1:0] addr_i,
    input  logic [BLEN_W-1:0]     len_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic [STRB_W-1:0]     wr_strb_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  rd_valid_o,
    output logic                  err_o,
    output logic                  busy_o,
    input  logic                  bd_en_i,
    input  logic                  bd_we_i,
    input  logic [ADDR_LINES-1:0] bd_addr_i,
    input  logic [WIDTH-1:0]      bd_wdata_i,
    output logic [WIDTH-1:0]      bd_rdata_o
);

    localparam logic [ADDR_LINES:0] LAST = (ADDR_LINES+1)'(DEPTH - 1);

    state_t                state_q, state_d;
    logic [ADDR_LINES-1:0] addr_q, addr_d;
    logic [BLEN_W-1:0]     remain_q, remain_d;
    logic                  rd_valid_q, bd_pend_q, err_q;
    logic [WIDTH-1:0]      rd_hold_q, bd_hold_q;
    logic [ADDR_LINES:0]   end_addr;
    logic                  fire, range_err, cmd_ok, cmd_err, rd_issue;
    logic                  arr_we, arr_re;
    logic [ADDR_LINES-1:0] arr_addr;
    logic [WIDTH-1:0]      arr_wdata, arr_rdata;
    logic [STRB_W-1:0]     arr_strb;

    assign end_addr  = {1'b0, addr_i} + (ADDR_LINES+1)'(len_i);
    assign range_err = end_addr > LAST;
    assign fire      = valid_i && ready_o;
    assign cmd_ok    = fire && state_q == IDLE && !range_err;
    assign cmd_err   = fire && state_q == IDLE && range_err;
    assign rd_issue  = state_q == RD && !bd_en_i && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        case (state_q)
            IDLE: if (cmd_ok) begin
                state_d  = wr_rd_i ? (len_i == '0 ? IDLE : WR) : RD;
                addr_d   = wr_rd_i ? addr_i + ADDR_LINES'(1) : addr_i;
                remain_d = len_i;
            end
            WR: if (fire) begin
                state_d  = remain_q == BLEN_W'(1) ? IDLE : WR;
                addr_d   = addr_q + ADDR_LINES'(1);
                remain_d = remain_q - BLEN_W'(1);
            end
            RD: if (rd_issue) begin
                state_d  = remain_q == '0 ? IDLE : RD;
                addr_d   = addr_q + ADDR_LINES'(1);
                remain_d = remain_q - BLEN_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Backdoor owns the RAM port whenever it is enabled.
    always_comb begin
        ready_o   = (state_q == IDLE || state_q == WR) && !bd_en_i && !rst_i;
        busy_o    = state_q != IDLE;
        arr_addr  = bd_en_i ? bd_addr_i : (state_q == IDLE ? addr_i : addr_q);
        arr_we    = bd_en_i ? bd_we_i
                            : fire && (state_q == WR || (state_q == IDLE && wr_rd_i && !range_err));
        arr_re    = bd_en_i ? !bd_we_i : rd_issue;
        arr_wdata = bd_en_i ? bd_wdata_i : wr_data_i;
        arr_strb  = bd_en_i ? '1 : wr_strb_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_q <= 1'b0;
            bd_pend_q  <= 1'b0;
            err_q      <= 1'b0;
            rd_hold_q  <= '0;
            bd_hold_q  <= '0;
        end else begin
            rd_valid_q <= rd_issue;
            bd_pend_q  <= bd_en_i && !bd_we_i;
            err_q      <= cmd_err;
            rd_hold_q  <= rd_valid_q ? arr_rdata : rd_hold_q;
            bd_hold_q  <= bd_pend_q ? arr_rdata : bd_hold_q;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_valid_q ? arr_rdata : rd_hold_q;
    assign bd_rdata_o = bd_pend_q ? arr_rdata : bd_hold_q;
    assign err_o      = err_q;

    mem_burst_array #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_LINES (ADDR_LINES),
        .STRB_W     (STRB_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .strb_i  (arr_strb),
        .rdata_o (arr_rdata)
    );

endmodule
